// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - command-driven write/read/scan/clear initiator for an 8-entry register file
// Optional bulk clear is compiled in with REGSEQ_CLEAR_EN; without it op 11 completes at once with err.
module regfile_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [2:0]       cmd_addr,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             we3,
    output logic [2:0]       wa3,
    output logic [WIDTH-1:0] wd3,
    output logic [2:0]       ra1,
    output logic [2:0]       ra2,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    output logic             rsp_valid,
    output logic [2:0]       rsp_addr,
    output logic [WIDTH-1:0] rsp_data1,
    output logic [WIDTH-1:0] rsp_data2,
    output logic             done,
    output logic             err,
    output logic             busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_SCAN  = 3'd3;
`ifdef REGSEQ_CLEAR_EN
    localparam logic [2:0] S_CLEAR = 3'd4;
`endif

    logic [2:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [2:0]       rsp_addr_q, rsp_addr_d;
    logic [WIDTH-1:0] rsp_data1_q, rsp_data1_d;
    logic [WIDTH-1:0] rsp_data2_q, rsp_data2_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    assign cmd_ready = (state_q == S_IDLE) & ~reset;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rsp_valid_d = 1'b0;
        rsp_addr_d  = rsp_addr_q;
        rsp_data1_d = rsp_data1_q;
        rsp_data2_d = rsp_data2_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d = cmd_addr;
                    data_d = cmd_data;
                    // Clear starts at r1: r0 is hardwired to zero in the register file.
                    idx_d  = (cmd_op == 2'b11) ? 3'd1 : 3'd0;
                    case (cmd_op)
                        2'b00: state_d = S_WRITE;
                        2'b01: state_d = S_READ;
                        2'b10: state_d = S_SCAN;
                        2'b11: begin
`ifdef REGSEQ_CLEAR_EN
                            state_d = S_CLEAR;
`else
                            done_d = 1'b1;
                            err_d  = 1'b1;
`endif
                        end
                    endcase
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            S_READ: begin
                rsp_valid_d = 1'b1;
                rsp_addr_d  = addr_q;
                rsp_data1_d = rd1;
                rsp_data2_d = rd2;
                state_d     = S_IDLE;
                done_d      = 1'b1;
            end
            S_SCAN: begin
                rsp_valid_d = 1'b1;
                rsp_addr_d  = idx_q;
                rsp_data1_d = rd1;
                idx_d       = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`ifdef REGSEQ_CLEAR_EN
            S_CLEAR: begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            addr_q      <= 3'd0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= 3'd0;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data1_q <= rsp_data1_d;
            rsp_data2_q <= rsp_data2_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Port drive is a pure decode of state and latched values so reset silences it immediately.
    always_comb begin
        we3 = 1'b0;
        wa3 = 3'd0;
        wd3 = '0;
        ra1 = 3'd0;
        ra2 = 3'd0;
        case (state_q)
            S_WRITE: begin
                we3 = 1'b1;
                wa3 = addr_q;
                wd3 = data_q;
            end
            S_READ: begin
                ra1 = addr_q;
                ra2 = addr_q + 3'd1;
            end
            S_SCAN: ra1 = idx_q;
`ifdef REGSEQ_CLEAR_EN
            S_CLEAR: begin
                we3 = 1'b1;
                wa3 = idx_q;
            end
`endif
            default: ;
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data1 = rsp_data1_q;
    assign rsp_data2 = rsp_data2_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - scoreboard bench for regfile_sequencer with a behavioural register-file model
module tb_regfile_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       we3;
    logic [2:0] wa3;
    logic [7:0] wd3;
    logic [2:0] ra1, ra2;
    logic [7:0] rd1, rd2;
    logic       rsp_valid;
    logic [2:0] rsp_addr;
    logic [7:0] rsp_data1, rsp_data2;
    logic       done, err, busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] a;
        logic [7:0] d1;
        logic [7:0] d2;
    } rsp_t;

    typedef struct packed {
        logic [2:0] a;
        logic [7:0] d;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];
    logic done_q[$];

    logic [7:0] mem[8];
    logic [7:0] last_d2;
    logic [7:0] rf[8];

    regfile_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .rsp_valid(rsp_valid), .rsp_addr(rsp_addr),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
        .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    always @(posedge clk) if (we3 && wa3 != 3'd0) rf[wa3] <= wd3;
    assign rd1 = (ra1 == 3'd0) ? 8'h00 : rf[ra1];
    assign rd2 = (ra2 == 3'd0) ? 8'h00 : rf[ra2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            checks++;
            if (rsp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_spurious actual addr=%0d d1=0x%0h required=no response", rsp_addr, rsp_data1);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                if ({rsp_addr, rsp_data1, rsp_data2} !== e) begin
                    failures++;
                    $display("FAIL rsp actual=%0d/0x%0h/0x%0h required=%0d/0x%0h/0x%0h",
                             rsp_addr, rsp_data1, rsp_data2, e.a, e.d1, e.d2);
                end
            end
        end
        if (we3) begin
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL wr_spurious actual wa3=%0d wd3=0x%0h required=no write", wa3, wd3);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                if ({wa3, wd3} !== w) begin
                    failures++;
                    $display("FAIL wr actual=%0d/0x%0h required=%0d/0x%0h", wa3, wd3, w.a, w.d);
                end
            end
        end
        if (done) begin
            checks++;
            if (done_q.size() == 0) begin
                failures++;
                $display("FAIL done_spurious actual done=1 required=0");
            end else begin
                logic e_err;
                e_err = done_q.pop_front();
                if (err !== e_err) begin
                    failures++;
                    $display("FAIL done_err actual=%0b required=%0b", err, e_err);
                end
            end
        end else if (err) begin
            checks++;
            failures++;
            $display("FAIL err_without_done actual=1 required=0");
        end
    end

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'b00: return 2;
            2'b01: return 2;
            2'b10: return 9;
`ifdef REGSEQ_CLEAR_EN
            default: return 8;
`else
            default: return 1;
`endif
        endcase
    endfunction

    // Reference model: applies each command's architectural effect and queues what must appear.
    task automatic model_cmd(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] data);
        logic [2:0] nxt;
        case (op)
            2'b00: begin
                wr_q.push_back({addr, data});
                if (addr != 3'd0) mem[addr] = data;
                done_q.push_back(1'b0);
            end
            2'b01: begin
                nxt = addr + 3'd1;
                last_d2 = mem[nxt];
                rsp_q.push_back({addr, mem[addr], last_d2});
                done_q.push_back(1'b0);
            end
            2'b10: begin
                for (int i = 0; i < 8; i++) rsp_q.push_back({3'(i), mem[i], last_d2});
                done_q.push_back(1'b0);
            end
            default: begin
`ifdef REGSEQ_CLEAR_EN
                for (int i = 1; i < 8; i++) begin
                    wr_q.push_back({3'(i), 8'h00});
                    mem[i] = 8'h00;
                end
                done_q.push_back(1'b0);
`else
                done_q.push_back(1'b1);
`endif
            end
        endcase
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] data);
        int cyc;
        int ready_bad;
        chk("ready_before_cmd", {31'b0, cmd_ready}, 32'd1);
        model_cmd(op, addr, data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = 3'($urandom);
        cmd_data  = 8'($urandom);
        cyc = 1;
        ready_bad = 0;
        while (!done && cyc <= 20) begin
            if (cmd_ready || !busy) ready_bad++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk($sformatf("latency_op%0d", op), cyc, lat_of(op));
        chk($sformatf("ready_low_op%0d", op), ready_bad, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        last_d2   = 8'h00;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 3'd0;
        cmd_data  = 8'h00;
        reset     = 1'b1;
        #1;
        chk("rst_outputs", {we3, wa3, wd3, ra1, ra2, rsp_valid, rsp_addr}, 32'd0);
        chk("rst_data", {rsp_data1, rsp_data2}, 32'd0);
        chk("rst_flags", {done, err, busy, cmd_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        do_cmd(2'b00, 3'd3, 8'hA5);
        do_cmd(2'b01, 3'd3, 8'h00);
        do_cmd(2'b00, 3'd7, 8'h3C);
        do_cmd(2'b01, 3'd7, 8'h00);
        do_cmd(2'b00, 3'd0, 8'hFF);
        do_cmd(2'b01, 3'd0, 8'h00);
        for (int i = 1; i < 8; i++) do_cmd(2'b00, 3'(i), 8'(8'h11 * i));
        do_cmd(2'b10, 3'd0, 8'h00);
        do_cmd(2'b11, 3'd0, 8'h00);
        do_cmd(2'b10, 3'd0, 8'h00);

        for (int i = 1; i < 8; i++) do_cmd(2'b00, 3'(i), 8'($urandom));
        // Abort a scan in cycle 5: only the pulses of cycles 2..4 may appear.
        chk("ready_before_abort", {31'b0, cmd_ready}, 32'd1);
        for (int i = 0; i < 3; i++) rsp_q.push_back({3'(i), mem[i], last_d2});
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_quiet", {rsp_valid, busy, we3, cmd_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        last_d2 = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_ready", {31'b0, cmd_ready}, 32'd1);
        do_cmd(2'b01, 3'd2, 8'h00);

        for (int n = 0; n < 40; n++)
            do_cmd(2'($urandom), 3'($urandom_range(7, 0)), 8'($urandom));
        do_cmd(2'b10, 3'd0, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        chk("rsp_q_empty", rsp_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Command-driven initiator for the 8-entry, 3-bit-addressed register file (write port we3/wa3/wd3, combinational read ports ra1/rd1 and ra2/rd2). It accepts one command at a time over a valid/ready handshake and turns it into register-file port activity. Commands are single write, paired read, full scan (dump r0..r7), and optional bulk clear. It sits between the board-level switch/button front end and the register file, and drives the display/LED path with read responses.

## Interface
- WIDTH, 8, data width; must equal the register file's WIDTH.
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept; `(state==IDLE) & ~reset`.
- cmd_op  in  2  00 WRITE, 01 READ, 10 SCAN, 11 CLEAR.
- cmd_addr  in  3  target register.
- cmd_data  in  WIDTH  write data (WRITE only).
- we3, wa3[2:0], wd3[WIDTH-1:0]  out  register-file write port.
- ra1[2:0], ra2[2:0]  out  register-file read addresses.
- rd1, rd2  in  WIDTH  register-file read data (combinational).
- rsp_valid  out  1  one-cycle pulse per read result.
- rsp_addr  out  3  address of rsp_data1.
- rsp_data1, rsp_data2  out  WIDTH  captured read data.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  pulses with done for an unsupported op.
- busy  out  1  `state != IDLE`.

## Operation
- FSM states: IDLE, WRITE, READ, SCAN, CLEAR. Handshake fires on a posedge with cmd_valid & cmd_ready. On that edge op/addr/data are latched, idx is loaded, and the FSM moves to the op's state. cmd_valid while busy is ignored; no queuing.
- Port drive is decoded from state and latched registers only.
  - IDLE: we3=0, and wa3, wd3, ra1, ra2 are all 0.
- WRITE: one cycle with we3=1, wa3=addr, wd3=data, then IDLE.
  - addr 0 is still issued; the register file discards it and r0 reads 0.
- READ: one cycle with ra1=addr, ra2=(addr+1) mod 8. 7 wraps to 0.
  - The edge captures rd1→rsp_data1, rd2→rsp_data2, addr→rsp_addr, and sets rsp_valid=1. Then IDLE.
- SCAN: idx runs 0..7, one register per cycle, with ra1=idx.
  - Each edge captures rd1→rsp_data1 and idx→rsp_addr, and pulses rsp_valid. rsp_data2 holds its last value.
  - Leaves after idx=7.
- CLEAR: idx runs 1..7 with we3=1, wa3=idx, wd3=0, one register per cycle. Leaves after idx=7.
- done is registered and is high for exactly one cycle after the last active cycle of each command.
- rsp_valid is registered; there is no backpressure, so the consumer must sample on the pulse.
- rsp_addr, rsp_data1 and rsp_data2 hold between pulses.

## Timing
- Accept edge = E0; cycle n is the cycle after edge En-1.
- WRITE: we3 high in cycle 1, data lands at E1, done in cycle 2.
- READ: ports driven in cycle 1; rsp_valid and done in cycle 2.
- SCAN: active cycles 1–8; rsp_valid in cycles 2–9; done in cycle 9, coincident with rsp_addr=7.
- CLEAR: we3 in cycles 1–7; done in cycle 8.
- cmd_ready is high again in the done cycle, so back-to-back commands are accepted one cycle apart.
- WRITE then READ of the same address returns the new value, because the write lands at E1 and the read is driven in cycle 3 at the earliest.
- Reset values, all applied asynchronously: state=IDLE, idx=0, and latched op/addr/data=0. Outputs are we3=0, wa3=0, wd3=0, ra1=0, ra2=0, rsp_valid=0, rsp_addr=0, rsp_data1=0, rsp_data2=0, done=0, err=0, busy=0, cmd_ready=0.
- Reset mid-command aborts immediately. we3 drops in the same cycle; no done or rsp_valid follows. Writes already landed are kept.

## Configuration
- REGSEQ_CLEAR_EN defined: op 11 executes CLEAR as described.
- REGSEQ_CLEAR_EN undefined: the CLEAR state and its logic are removed. Op 11 is still accepted, drives no port activity, and pulses done and err together in cycle 1 after acceptance. err is constant 0 for all other ops in both builds.

## Test plan
- Reset; WRITE addr 3 data 0xA5 → we3=1, wa3=3, wd3=0xA5 in cycle 1 only; done in cycle 2. READ addr 3 → rsp_data1=0xA5, rsp_data2=r4, rsp_addr=3.
- WRITE addr 7 data 0x3C, then READ addr 7 → ra2=0; rsp_data1=0x3C, rsp_data2=0x00.
- WRITE addr 0 data 0xFF, then READ 0 → rsp_data1=0x00.
- Write r1..r7 = 0x11·i; SCAN → eight consecutive rsp_valid pulses with rsp_addr 0..7 and data 00,11,…,77; done with the last pulse; cmd_ready=0 for cycles 1–8.
- CLEAR with REGSEQ_CLEAR_EN: we3 for 7 cycles on addresses 1..7, done in cycle 8, subsequent SCAN returns all 0x00. CLEAR without it: no we3, done=err=1 in cycle 1.
- Assert reset in SCAN cycle 5 → rsp_valid, busy and we3 are 0 at once and no done follows. After release, cmd_ready=1 and the next READ completes normally.
